acc_sample_sequencer: RTL and testbench
=======================================

# acc_sample_sequencer

Periodic read controller between the I2C driver and the position estimator core. It paces accelerometer reads with a programmable tick, issues one start pulse per read, and waits for completion with a timeout. It assembles the two received bytes into a signed 16-bit acceleration sample and delivers it to the estimator over a valid/ready handshake. It replaces the free-running latch on the driver's end flag and counts dropped ticks and timeouts.

## Interface

Parameters:
- TICK_PERIOD, 50000: clock cycles between read requests (≥ 4).
- TIMEOUT, 4096: maximum cycles to wait for read completion (≥ 2).
- REG_ADDR, 8'h3B: sensor register address presented with each request.
- CAL_LOG2, 4: log2 of the number of calibration samples; used only with ACC_SEQ_CAL_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request.
- i2c_start  out  1  one-cycle read request pulse to the driver.
- i2c_reg  out  8  register address; constant REG_ADDR.
- i2c_done  in  1  one-cycle completion pulse, already synchronous to clk.
- i2c_data_hi  in  8  first received byte; valid in the i2c_done cycle.
- i2c_data_lo  in  8  second received byte; valid in the i2c_done cycle.
- acc_out  out  16  signed sample to the estimator.
- acc_valid  out  1  acc_out valid.
- acc_ready  in  1  estimator accepts the sample.
- busy  out  1  high in any state other than IDLE.
- cal_done  out  1  bias calibration complete.
- overrun_cnt  out  8  saturating count of dropped ticks.
- timeout_cnt  out  8  saturating count of read timeouts.

## Operation

- FSM states: IDLE, WAIT_TICK, START, WAIT_DONE, PUSH.
- IDLE: enters WAIT_TICK when enable=1. The tick counter is cleared in IDLE.
- Tick counter: free-runs 0..TICK_PERIOD-1 whenever state≠IDLE. A tick is the cycle it wraps to 0.
- WAIT_TICK:
  - On a tick, go to START.
  - If enable=0, go to IDLE immediately.
- START: i2c_start=1 for exactly one cycle, then WAIT_DONE.
- WAIT_DONE: the timeout counter starts at 0 and increments each cycle.
  - On i2c_done, capture {i2c_data_hi, i2c_data_lo} and go to PUSH.
  - If the counter reaches TIMEOUT-1 without i2c_done, increment timeout_cnt and go to WAIT_TICK.
  - If i2c_done and the timeout coincide, i2c_done wins and timeout_cnt is unchanged.
- PUSH: acc_valid=1 and acc_out is held stable until acc_ready=1. On that cycle go to WAIT_TICK, or to IDLE if enable=0.
- Any tick outside WAIT_TICK is dropped and increments overrun_cnt.
- enable=0 outside WAIT_TICK lets the current transaction complete (sample, timeout) before returning to IDLE.
- i2c_done outside WAIT_DONE is ignored.
- Counters saturate at 8'hFF. They clear only on reset.

## Timing

- Reset values: state IDLE; i2c_start=0, acc_out=0, acc_valid=0, busy=0, overrun_cnt=0, timeout_cnt=0; cal_done=0 with ACC_SEQ_CAL_EN, 1 without.
- Assertion of reset is asynchronous in any state; a pending request is abandoned and no pulse is emitted.
- Latency:
  - enable rise to first i2c_start: TICK_PERIOD+1 cycles.
  - i2c_done cycle to acc_valid=1: 1 cycle.
- acc_out and acc_valid are registered. Handshake completes on the rising edge where acc_valid and acc_ready are both 1.
- i2c_reg is constant. All other outputs are registered.

## Configuration

- Macro ACC_SEQ_CAL_EN.
- Defined:
  - The first 2^CAL_LOG2 successfully read samples after reset are summed into a signed (16+CAL_LOG2)-bit accumulator. They are not pushed; acc_valid stays 0 and the FSM returns from the capture directly to WAIT_TICK.
  - Then bias = accumulator >>> CAL_LOG2 (arithmetic shift) and cal_done=1.
  - Every later sample is output as sat16(raw − bias), computed at 17 bits and clamped to [0x8000, 0x7FFF].
- Undefined: no accumulator, cal_done tied to 1, acc_out = raw sample.

## Structure

- Package acc_seq_pkg holds:
  - the state enum;
  - the sat16 function;
  - default constants for TICK_PERIOD, TIMEOUT and REG_ADDR.
- Sub-module acc_seq_tick holds the tick counter. Inputs: clk, reset, run. Output: tick pulse. Parameter: TICK_PERIOD.

## Test plan

Bench parameters: TICK_PERIOD=100, TIMEOUT=16.

- Nominal read: enable=1; i2c_done 5 cycles after i2c_start with hi=0x12, lo=0x34 -> i2c_start with i2c_reg=0x3B at cycle 101; next cycle acc_out=0x1234, acc_valid=1; accepted with acc_ready=1.
- Backpressure: acc_ready=0 for 250 cycles after acc_valid -> acc_out stays 0x1234, no new i2c_start, overrun_cnt=2 (tick 100 may give 2 or 3; check the exact count against tick phase).
- Timeout: no i2c_done -> 16 cycles after i2c_start, timeout_cnt=1, no acc_valid; a late i2c_done is ignored; the next read starts on the next tick.
- Simultaneous: i2c_done on the last timeout cycle -> sample delivered, timeout_cnt unchanged.
- Calibration (ACC_SEQ_CAL_EN, CAL_LOG2=2): samples 0x0010, 0x0012, 0x000E, 0x0010 -> no acc_valid, cal_done=1, bias=0x0010; fifth sample 0x8005 -> acc_out=0x8000 (saturated); sixth sample 0x0020 -> acc_out=0x0010.
- Reset in WAIT_DONE: reset=0 for 2 cycles -> all outputs at reset values immediately; after release with enable=1, first i2c_start again TICK_PERIOD+1 cycles later.

Source files
------------

// File: rtl/acc_seq_pkg.sv
// Shared types, defaults and helpers for the accelerometer sample sequencer.
package acc_seq_pkg;

  localparam int unsigned TICK_PERIOD_DEF = 50000;
  localparam int unsigned TIMEOUT_DEF     = 4096;
  localparam logic [7:0]  REG_ADDR_DEF    = 8'h3B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_START,
    ST_WAIT_DONE,
    ST_PUSH
  } state_e;

  // Clamp a 17-bit signed difference into the signed 16-bit range.
  function automatic logic [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) return v[16] ? 16'h8000 : 16'h7FFF;
    return v[15:0];
  endfunction

endpackage

// File: rtl/acc_seq_tick.sv
// Read-pacing tick: counts 0..TICK_PERIOD-1 while run is high, held at 0 otherwise.
// tick is high in the last count cycle, i.e. the cycle whose edge wraps the counter.
module acc_seq_tick
  import acc_seq_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = TICK_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(TICK_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/acc_sample_sequencer.sv
// Periodic accelerometer read controller: paced I2C requests, timeout, sample handoff.
// Bias calibration of the delivered samples is built only when ACC_SEQ_CAL_EN is defined.
//
// state        | meaning
// ST_IDLE      | stopped, tick counter cleared
// ST_WAIT_TICK | running, waiting for the next read tick
// ST_START     | one-cycle request pulse to the I2C driver
// ST_WAIT_DONE | waiting for completion, timeout counter running
// ST_PUSH      | sample presented to the estimator until accepted
module acc_sample_sequencer
  import acc_seq_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = TICK_PERIOD_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter logic [7:0]  REG_ADDR    = REG_ADDR_DEF,
  parameter int unsigned CAL_LOG2    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        i2c_start,
  output logic [7:0]  i2c_reg,
  input  logic        i2c_done,
  input  logic [7:0]  i2c_data_hi,
  input  logic [7:0]  i2c_data_lo,
  output logic [15:0] acc_out,
  output logic        acc_valid,
  input  logic        acc_ready,
  output logic        busy,
  output logic        cal_done,
  output logic [7:0]  overrun_cnt,
  output logic [7:0]  timeout_cnt
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  if (TICK_PERIOD < 4 || TIMEOUT < 2 || CAL_LOG2 < 1 || CAL_LOG2 > 8) begin : g_param_check
    $error("acc_sample_sequencer: parameter out of range");
  end

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [15:0]        acc_out_q, acc_out_d;
  logic [7:0]         ovr_q, ovr_d;
  logic [7:0]         tcnt_q, tcnt_d;
  logic               start_q, valid_q, busy_q;
  logic               run, tick;
  logic signed [15:0] raw;

  assign raw = $signed({i2c_data_hi, i2c_data_lo});
  assign run = (state_q != ST_IDLE);

  acc_seq_tick #(.TICK_PERIOD(TICK_PERIOD)) u_tick (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .tick (tick)
  );

`ifdef ACC_SEQ_CAL_EN
  localparam int unsigned SW = 16 + CAL_LOG2;
  logic signed [SW-1:0]   sum_q, sum_d, sum_new;
  logic [CAL_LOG2-1:0]    cal_cnt_q, cal_cnt_d;
  logic                   cal_done_q, cal_done_d;
  logic signed [15:0]     bias_q, bias_d;
  logic signed [16:0]     diff;

  assign sum_new = sum_q + SW'(raw);
  assign diff    = 17'(raw) - 17'(bias_q);
`endif

  always_comb begin
    state_d   = state_q;
    tmo_d     = '0;
    acc_out_d = acc_out_q;
    ovr_d     = ovr_q;
    tcnt_d    = tcnt_q;
`ifdef ACC_SEQ_CAL_EN
    sum_d      = sum_q;
    cal_cnt_d  = cal_cnt_q;
    cal_done_d = cal_done_q;
    bias_d     = bias_q;
`endif
    // A tick only advances the FSM from WAIT_TICK; anywhere else it is lost.
    if (tick && state_q != ST_WAIT_TICK && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (!enable)   state_d = ST_IDLE;
        else if (tick) state_d = ST_START;
      end
      ST_START: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        tmo_d = tmo_q + 1'b1;
        if (i2c_done) begin
`ifdef ACC_SEQ_CAL_EN
          if (!cal_done_q) begin
            sum_d     = sum_new;
            cal_cnt_d = cal_cnt_q + 1'b1;
            if (&cal_cnt_q) begin
              cal_done_d = 1'b1;
              bias_d     = 16'(sum_new >>> CAL_LOG2);
            end
            state_d = ST_WAIT_TICK;
          end else begin
            acc_out_d = sat16(diff);
            state_d   = ST_PUSH;
          end
`else
          acc_out_d = raw;
          state_d   = ST_PUSH;
`endif
        end else if (tmo_q == TMO_LAST) begin
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d = ST_WAIT_TICK;
        end
      end
      ST_PUSH: begin
        if (acc_ready) state_d = enable ? ST_WAIT_TICK : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      acc_out_q <= '0;
      ovr_q     <= '0;
      tcnt_q    <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      acc_out_q <= acc_out_d;
      ovr_q     <= ovr_d;
      tcnt_q    <= tcnt_d;
      start_q   <= (state_d == ST_START);
      valid_q   <= (state_d == ST_PUSH);
      busy_q    <= (state_d != ST_IDLE);
    end
  end

`ifdef ACC_SEQ_CAL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q      <= '0;
      cal_cnt_q  <= '0;
      cal_done_q <= 1'b0;
      bias_q     <= '0;
    end else begin
      sum_q      <= sum_d;
      cal_cnt_q  <= cal_cnt_d;
      cal_done_q <= cal_done_d;
      bias_q     <= bias_d;
    end
  end

  assign cal_done = cal_done_q;
`else
  assign cal_done = 1'b1;
`endif

  assign i2c_start   = start_q;
  assign i2c_reg     = REG_ADDR;
  assign acc_out     = acc_out_q;
  assign acc_valid   = valid_q;
  assign busy        = busy_q;
  assign overrun_cnt = ovr_q;
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_acc_sample_sequencer.sv
// Self-checking bench for acc_sample_sequencer; expected timing comes from tick arithmetic
// (ticks every P cycles after enable), not from the FSM encoding.
module tb_acc_sample_sequencer;

  localparam int P     = 100;
  localparam int TO    = 16;
  localparam int CAL_N = 4;

  logic        clk, reset, enable, i2c_start, i2c_done, acc_valid, acc_ready, busy, cal_done;
  logic [7:0]  i2c_reg, i2c_data_hi, i2c_data_lo, overrun_cnt, timeout_cnt;
  logic [15:0] acc_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int e_base, s_next, ovr_exp, tmo_exp, cal_seen, cal_sum, bias;
  logic [15:0] obs_out;

  acc_sample_sequencer #(.TICK_PERIOD(P), .TIMEOUT(TO), .REG_ADDR(8'h3B), .CAL_LOG2(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .i2c_start  (i2c_start),
    .i2c_reg    (i2c_reg),
    .i2c_done   (i2c_done),
    .i2c_data_hi(i2c_data_hi),
    .i2c_data_lo(i2c_data_lo),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .busy       (busy),
    .cal_done   (cal_done),
    .overrun_cnt(overrun_cnt),
    .timeout_cnt(timeout_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic model_reset();
    e_base   = cyc;
    s_next   = cyc + P + 1;
    ovr_exp  = 0;
    tmo_exp  = 0;
    cal_seen = 0;
    cal_sum  = 0;
    bias     = 0;
  endtask

  // One read: i2c_done d cycles after the start pulse (d > TO means timeout),
  // then acc_ready raised r cycles after acc_valid.
  task automatic do_txn(input int d, input logic [15:0] raw, input int r, input string tag);
    int budget, s, f, nt, v;
    bit absorb, seen_start;
    logic [15:0] exp_out;
    obs_out = 'x;
    budget = s_next - cyc + 10;
    while (i2c_start !== 1'b1 && budget > 0) begin
      step();
      budget--;
    end
    n_checks++;
    if (i2c_start !== 1'b1 || cyc != s_next) begin
      n_fail++;
      $display("FAIL %s start_cycle: actual cycle %0d (start=%b), required cycle %0d", tag, cyc, i2c_start, s_next);
      return;
    end
    s = cyc;
    n_checks++;
    if (i2c_reg !== 8'h3B || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s reg_busy: actual reg=%h busy=%b, required reg=3b busy=1", tag, i2c_reg, busy);
    end
    if (d <= TO) begin
      step_to(s + d);
      i2c_done = 1'b1;
      {i2c_data_hi, i2c_data_lo} = raw;
      step();
      i2c_done = 1'b0;
      {i2c_data_hi, i2c_data_lo} = 16'($urandom);
      absorb = 1'b0;
`ifdef ACC_SEQ_CAL_EN
      if (cal_seen < CAL_N) begin
        absorb = 1'b1;
        cal_sum += $signed(raw);
        cal_seen++;
        if (cal_seen == CAL_N) bias = cal_sum >>> 2;
        n_checks++;
        if (acc_valid !== 1'b0 || cal_done !== (cal_seen == CAL_N)) begin
          n_fail++;
          $display("FAIL %s cal_absorb: actual valid=%b cal_done=%b, required valid=0 cal_done=%b",
                   tag, acc_valid, cal_done, cal_seen == CAL_N);
        end
      end
`endif
      if (!absorb) begin
        v = $signed(raw) - bias;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        exp_out = 16'(v);
        obs_out = acc_out;
        n_checks++;
        if (acc_valid !== 1'b1 || acc_out !== exp_out) begin
          n_fail++;
          $display("FAIL %s sample: actual valid=%b out=%h, required valid=1 out=%h", tag, acc_valid, acc_out, exp_out);
        end
        seen_start = 1'b0;
        repeat (r) begin
          step();
          if (i2c_start === 1'b1) seen_start = 1'b1;
        end
        acc_ready = 1'b1;
        n_checks++;
        if (acc_valid !== 1'b1 || acc_out !== exp_out || seen_start) begin
          n_fail++;
          $display("FAIL %s hold: actual valid=%b out=%h start_seen=%b, required valid=1 out=%h start_seen=0",
                   tag, acc_valid, acc_out, seen_start, exp_out);
        end
        step();
        acc_ready = 1'b0;
        n_checks++;
        if (acc_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s release: actual valid=%b, required valid=0", tag, acc_valid);
        end
      end
      f = cyc;
    end else begin
      step_to(s + TO + 1);
      if (tmo_exp < 255) tmo_exp++;
      n_checks++;
      if (timeout_cnt !== 8'(tmo_exp) || acc_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s timeout: actual cnt=%0d valid=%b, required cnt=%0d valid=0", tag, timeout_cnt, acc_valid, tmo_exp);
      end
      f = cyc;
      step_to(s + d);
      i2c_done = 1'b1;
      {i2c_data_hi, i2c_data_lo} = raw;
      step();
      i2c_done = 1'b0;
      n_checks++;
      if (acc_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s late_done: actual valid=%b, required valid=0", tag, acc_valid);
      end
    end
    nt = (f - 1 - e_base) / P - (s - 1 - e_base) / P;
    ovr_exp = (ovr_exp + nt > 255) ? 255 : ovr_exp + nt;
    n_checks++;
    if (overrun_cnt !== 8'(ovr_exp)) begin
      n_fail++;
      $display("FAIL %s overrun: actual %0d, required %0d", tag, overrun_cnt, ovr_exp);
    end
    s_next = e_base + ((f - e_base + P - 1) / P) * P + 1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; i2c_done = 1'b0; acc_ready = 1'b0;
    i2c_data_hi = 8'h00; i2c_data_lo = 8'h00;
    repeat (3) step();
    reset = 1'b1;
    step();
    n_checks++;
`ifdef ACC_SEQ_CAL_EN
    if (cal_done !== 1'b0) begin
`else
    if (cal_done !== 1'b1) begin
`endif
      n_fail++;
      $display("FAIL reset cal_done: actual %b", cal_done);
    end
    n_checks++;
    if (i2c_start !== 1'b0 || acc_out !== 16'h0 || acc_valid !== 1'b0 || busy !== 1'b0 ||
        overrun_cnt !== 8'h0 || timeout_cnt !== 8'h0 || i2c_reg !== 8'h3B) begin
      n_fail++;
      $display("FAIL reset outputs: actual start=%b out=%h valid=%b busy=%b ovr=%h tmo=%h reg=%h, required 0/0000/0/0/00/00/3b",
               i2c_start, acc_out, acc_valid, busy, overrun_cnt, timeout_cnt, i2c_reg);
    end
  endtask

  task automatic test_nominal();
    enable = 1'b1;
    model_reset();
    do_txn(5, 16'h1234, 0, "nominal");
  endtask

  task automatic test_backpressure();
    do_txn(5, 16'h1234, 250, "backpressure");
  endtask

  task automatic test_timeout();
    do_txn(20, 16'h5A5A, 0, "timeout");
  endtask

  task automatic test_simultaneous();
    do_txn(TO, 16'hFEDC, 3, "simultaneous");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      do_txn($urandom_range(1, TO + 4), 16'($urandom), $urandom_range(0, 120), "random");
  endtask

  task automatic test_saturation();
    do_txn(3, 16'h0123, 25700, "overrun_sat");
  endtask

  task automatic test_reset_wait_done();
    int budget;
    budget = s_next - cyc + 10;
    while (i2c_start !== 1'b1 && budget > 0) begin
      step();
      budget--;
    end
    n_checks++;
    if (i2c_start !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait_done start: actual start=%b at cycle %0d, required 1", i2c_start, cyc);
    end
    step_to(cyc + 3);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (i2c_start !== 1'b0 || acc_out !== 16'h0 || acc_valid !== 1'b0 || busy !== 1'b0 ||
        overrun_cnt !== 8'h0 || timeout_cnt !== 8'h0) begin
      n_fail++;
      $display("FAIL rst_async outputs: actual start=%b out=%h valid=%b busy=%b ovr=%h tmo=%h, required all 0",
               i2c_start, acc_out, acc_valid, busy, overrun_cnt, timeout_cnt);
    end
    step();
    step();
    n_checks++;
    if (i2c_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_held: actual start=%b busy=%b, required 0 0", i2c_start, busy);
    end
    reset = 1'b1;
    model_reset();
    do_txn(5, 16'h4321, 0, "after_reset");
  endtask

`ifdef ACC_SEQ_CAL_EN
  task automatic test_calibration();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    model_reset();
    do_txn(4, 16'h0010, 0, "cal0");
    do_txn(6, 16'h0012, 0, "cal1");
    do_txn(2, 16'h000E, 0, "cal2");
    do_txn(9, 16'h0010, 0, "cal3");
    n_checks++;
    if (cal_done !== 1'b1) begin
      n_fail++;
      $display("FAIL cal_done: actual %b, required 1", cal_done);
    end
    do_txn(5, 16'h8005, 0, "cal_sat");
    n_checks++;
    if (obs_out !== 16'h8000) begin
      n_fail++;
      $display("FAIL cal_sat value: actual %h, required 8000", obs_out);
    end
    do_txn(5, 16'h0020, 2, "cal_sub");
    n_checks++;
    if (obs_out !== 16'h0010) begin
      n_fail++;
      $display("FAIL cal_sub value: actual %h, required 0010", obs_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_simultaneous();
    test_random();
    test_saturation();
    test_reset_wait_done();
`ifdef ACC_SEQ_CAL_EN
    test_calibration();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
